usb_rx_data_ctrl: RTL and testbench

//  Sequences the device-side DATA phase after an OUT/SETUP token. Opens/closes rx_data_on to the CRC16 receive stage.

---
 rtl/usb_pkg.sv | 20 ++
 rtl/usb_timeout_cnt.sv | 25 ++
 rtl/usb_rx_data_ctrl.sv | 154 +++++++++++++++
 tb/tb_usb_rx_data_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: PID constants, FSM state encoding and DATA PID check shared by the
// USB receive data-phase controller.
//   PID_ACK/PID_NAK/PID_STALL : handshake PIDs (low nibble)
//   PID_DATA0/PID_DATA1       : data PIDs (low nibble)
//   state_t                   : data-phase FSM states
//   pid_data_ok()             : 1 when a PID byte is a well-formed DATA0/DATA1
package usb_pkg;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    typedef enum logic [2:0] {S_IDLE, S_WAIT_SOP, S_RECV, S_CHECK, S_HS} state_t;

    // Upper nibble must be the one's complement of the PID nibble.
    function automatic logic pid_data_ok(input logic [7:0] b);
        return (b[3:0] == PID_DATA0 || b[3:0] == PID_DATA1) && b[7:4] == ~b[3:0];
    endfunction
endpackage

// File: rtl/usb_timeout_cnt.sv
// usb_timeout_cnt: clearable, enabled up-counter that flags the cycle in which
// it reaches TIMEOUT_CYC-1 while enabled.
//   clk, rst : clock, synchronous active-high reset
//   clr      : return count to 0 (wins over en)
//   en       : count this cycle
//   expire   : en && count == TIMEOUT_CYC-1
module usb_timeout_cnt #(
    parameter int CNT_W       = 7,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en)    cnt <= cnt + 1'b1;
    end

    assign expire = en && cnt == CNT_W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/usb_rx_data_ctrl.sv
// usb_rx_data_ctrl: device-side DATA phase sequencer after an OUT/SETUP token.
// Gates the CRC16 receive stage, checks PID/byte count/CRC16, tracks the data
// toggle and requests an ACK/NAK(/STALL) handshake.
// Optional feature macro: USB_RX_STALL_EN adds input ep_stall (STALL handshake).
//   clk, rst          : clock, synchronous active-high reset
//   token_ok          : valid OUT/SETUP token pulse; token_setup 1=SETUP
//   ep_ready          : endpoint can take a packet (sampled at token_ok)
//   ep_stall          : endpoint halted (only with USB_RX_STALL_EN)
//   rx_data_on        : enables the CRC16 receive stage
//   rx_sop_en/rx_data : PID byte strobe and byte stream
//   rx_lt_valid/ready : transfer-layer byte handshake
//   rx_lt_eop_en      : last byte pulse; crc16_err valid one cycle later
//   hs_req/hs_pid     : handshake request/PID, held until hs_ack
//   data_accept/drop  : good packet commit / duplicate discard pulses
//   err_pulse         : timeout, bad PID, CRC16 error or overflow pulse
//   toggle            : expected data toggle (0=DATA0)
module usb_rx_data_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int MAX_BYTES   = 66,
    parameter int CNT_W       = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       token_ok,
    input  logic       token_setup,
    input  logic       ep_ready,
`ifdef USB_RX_STALL_EN
    input  logic       ep_stall,
`endif
    output logic       rx_data_on,
    input  logic       rx_sop_en,
    input  logic [7:0] rx_data,
    input  logic       rx_lt_valid,
    input  logic       rx_lt_ready,
    input  logic       rx_lt_eop_en,
    input  logic       crc16_err,
    output logic       hs_req,
    output logic [3:0] hs_pid,
    input  logic       hs_ack,
    output logic       data_accept,
    output logic       data_drop,
    output logic       err_pulse,
    output logic       toggle
);
    state_t           state;
    logic             nak, pid_tog, ovf, tout;
    logic [CNT_W-1:0] bcnt, bcnt_inc;
    logic             byte_ok, t_clr, t_en;
`ifdef USB_RX_STALL_EN
    logic             stall;
`else
    localparam logic  stall = 1'b0;
`endif

    assign byte_ok  = rx_lt_valid && rx_lt_ready;
    assign bcnt_inc = (bcnt == '1) ? bcnt : bcnt + 1'b1;
    // Timeout restarts on every accepted byte, including the PID byte.
    assign t_clr = state == S_IDLE || (state == S_WAIT_SOP && rx_sop_en) || (state == S_RECV && byte_ok);
    assign t_en  = (state == S_WAIT_SOP && !rx_sop_en) || (state == S_RECV && !byte_ok && !rx_lt_eop_en);

    usb_timeout_cnt #(.CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_tcnt (
        .clk(clk), .rst(rst), .clr(t_clr), .en(t_en), .expire(tout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            nak         <= 1'b0;
            pid_tog     <= 1'b0;
            ovf         <= 1'b0;
            bcnt        <= '0;
            rx_data_on  <= 1'b0;
            hs_req      <= 1'b0;
            hs_pid      <= 4'b0;
            data_accept <= 1'b0;
            data_drop   <= 1'b0;
            err_pulse   <= 1'b0;
            toggle      <= 1'b0;
`ifdef USB_RX_STALL_EN
            stall       <= 1'b0;
`endif
        end else begin
            data_accept <= 1'b0;
            data_drop   <= 1'b0;
            err_pulse   <= 1'b0;
            case (state)
                S_IDLE: if (token_ok) begin
                    nak        <= !ep_ready && !token_setup;
`ifdef USB_RX_STALL_EN
                    stall      <= ep_stall && !token_setup;
`endif
                    if (token_setup) toggle <= 1'b0;
                    bcnt       <= '0;
                    ovf        <= 1'b0;
                    rx_data_on <= 1'b1;
                    state      <= S_WAIT_SOP;
                end
                S_WAIT_SOP: if (rx_sop_en) begin
                    if (pid_data_ok(rx_data)) begin
                        pid_tog <= rx_data[3];
                        bcnt    <= CNT_W'(1);
                        state   <= S_RECV;
                    end else begin
                        err_pulse  <= 1'b1;
                        rx_data_on <= 1'b0;
                        state      <= S_IDLE;
                    end
                end else if (tout) begin
                    err_pulse  <= 1'b1;
                    rx_data_on <= 1'b0;
                    state      <= S_IDLE;
                end
                S_RECV: begin
                    if (byte_ok) begin
                        bcnt <= bcnt_inc;
                        if (bcnt_inc > CNT_W'(MAX_BYTES)) ovf <= 1'b1;
                    end
                    if (rx_lt_eop_en) begin
                        rx_data_on <= 1'b0;
                        state      <= S_CHECK;
                    end else if (tout) begin
                        err_pulse  <= 1'b1;
                        rx_data_on <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_CHECK: if (crc16_err || ovf) begin
                    err_pulse <= 1'b1;
                    state     <= S_IDLE;
                end else begin
                    hs_req <= 1'b1;
                    state  <= S_HS;
                    if (stall) hs_pid <= PID_STALL;
                    else if (nak) hs_pid <= PID_NAK;
                    else begin
                        hs_pid <= PID_ACK;
                        if (pid_tog == toggle) begin
                            data_accept <= 1'b1;
                            toggle      <= ~toggle;
                        end else data_drop <= 1'b1;
                    end
                end
                S_HS: if (hs_ack) begin
                    hs_req <= 1'b0;
                    hs_pid <= 4'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_rx_data_ctrl.sv
// tb_usb_rx_data_ctrl: directed self-checking bench for usb_rx_data_ctrl.
module tb_usb_rx_data_ctrl;
    logic       clk = 0, rst = 1;
    logic       token_ok = 0, token_setup = 0, ep_ready = 0;
    logic       rx_sop_en = 0, rx_lt_valid = 0, rx_lt_ready = 0, rx_lt_eop_en = 0;
    logic       crc16_err = 0, hs_ack = 0;
    logic [7:0] rx_data = 0;
    logic       rx_data_on, hs_req, data_accept, data_drop, err_pulse, toggle;
    logic [3:0] hs_pid;
`ifdef USB_RX_STALL_EN
    logic       ep_stall = 0;
`endif
    int tests = 0, fails = 0;

    usb_rx_data_ctrl dut (
        .clk(clk), .rst(rst), .token_ok(token_ok), .token_setup(token_setup), .ep_ready(ep_ready),
`ifdef USB_RX_STALL_EN
        .ep_stall(ep_stall),
`endif
        .rx_data_on(rx_data_on), .rx_sop_en(rx_sop_en), .rx_data(rx_data),
        .rx_lt_valid(rx_lt_valid), .rx_lt_ready(rx_lt_ready), .rx_lt_eop_en(rx_lt_eop_en),
        .crc16_err(crc16_err), .hs_req(hs_req), .hs_pid(hs_pid), .hs_ack(hs_ack),
        .data_accept(data_accept), .data_drop(data_drop), .err_pulse(err_pulse), .toggle(toggle)
    );

    always #5 clk = ~clk;

    wire [9:0] outs = {rx_data_on, hs_req, hs_pid, data_accept, data_drop, err_pulse, toggle};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic token(input logic setup, input logic ready);
        token_ok = 1; token_setup = setup; ep_ready = ready;
        tick();
        token_ok = 0; token_setup = 0;
    endtask

    task automatic sop(input logic [7:0] pid);
        rx_sop_en = 1; rx_data = pid;
        tick();
        rx_sop_en = 0; rx_data = 0;
    endtask

    // n transfer-layer bytes, EOP on the last, then the CHECK cycle.
    task automatic body(input int n, input logic bad_crc);
        for (int i = 0; i < n; i++) begin
            rx_lt_valid = 1; rx_lt_ready = 1; rx_lt_eop_en = (i == n - 1);
            rx_data = 8'(i);
            tick();
        end
        rx_lt_valid = 0; rx_lt_ready = 0; rx_lt_eop_en = 0;
        crc16_err = bad_crc;
        tick();
        crc16_err = 0;
    endtask

    task automatic ack_hs(input string tag);
        hs_ack = 1;
        tick();
        hs_ack = 0;
        check(tag, {hs_req, hs_pid}, 5'h0);
    endtask

    initial begin
        tick(); tick();
        check("reset_outs", outs, 0);
        rst = 0;
        tick();
        check("idle_outs", outs, 0);

        token(0, 1);
        check("t1_data_on", rx_data_on, 1);
        sop(8'hC3);
        body(6, 0);
        check("t1_hs", {hs_req, hs_pid}, {1'b1, 4'b0010});
        check("t1_acc_drop_err", {data_accept, data_drop, err_pulse}, 3'b100);
        check("t1_toggle", toggle, 1);
        tick();
        check("t1_pulse_width", {data_accept, hs_req}, 2'b01);
        ack_hs("t1_hs_release");

        token(0, 1);
        sop(8'hC3);
        body(6, 0);
        check("t2_hs", {hs_req, hs_pid}, {1'b1, 4'b0010});
        check("t2_dup", {data_accept, data_drop, toggle}, 3'b011);
        ack_hs("t2_hs_release");
        token(0, 1);
        sop(8'hC3);
        body(6, 1);
        check("t2_crc_err", {err_pulse, hs_req, data_accept, data_drop}, 4'b1000);
        tick();
        check("t2_crc_after", {err_pulse, hs_req, rx_data_on}, 3'b000);

        token(0, 0);
        sop(8'hC3);
        body(4, 0);
        check("t3_nak", {hs_req, hs_pid, data_accept, data_drop, toggle}, {1'b1, 4'b1010, 3'b001});
        ack_hs("t3_nak_release");
        token(1, 0);
        check("t3_setup_toggle", toggle, 0);
        sop(8'hC3);
        body(4, 0);
        check("t3_setup_ack", {hs_req, hs_pid, data_accept, toggle}, {1'b1, 4'b0010, 2'b11});
        ack_hs("t3_setup_release");

        begin
            int n = 0;
            token(0, 1);
            while (n < 100 && !err_pulse) begin
                tick();
                n++;
            end
            check("t4_timeout_cycle", n, 64);
            check("t4_timeout_outs", {err_pulse, rx_data_on, hs_req}, 3'b100);
        end
        token(0, 1);
        for (int i = 0; i < 63; i++) tick();
        check("t4_pre_expiry", {err_pulse, rx_data_on}, 2'b01);
        sop(8'hC3);
        check("t4_sop_wins", {err_pulse, rx_data_on}, 2'b01);
        body(2, 0);
        check("t4_sop_hs", {hs_req, hs_pid, data_drop}, {1'b1, 4'b0010, 1'b1});
        ack_hs("t4_release");

        token(0, 1);
        sop(8'hC4);
        check("t5_bad_pid", {err_pulse, rx_data_on, hs_req}, 3'b100);
        token(0, 1);
        sop(8'hC3);
        body(66, 0);
        check("t5_overflow", {err_pulse, hs_req, data_accept, data_drop}, 4'b1000);
        tick();
        check("t5_overflow_no_hs", hs_req, 0);
        token(0, 1);
        sop(8'hC3);
        body(65, 0);
        check("t5_max_bytes_ok", {err_pulse, hs_req, hs_pid}, {2'b01, 4'b0010});
        ack_hs("t5_release");

        token(0, 1);
        sop(8'hC3);
        rx_lt_valid = 1; rx_lt_ready = 1;
        tick(); tick();
        rx_lt_valid = 0; rx_lt_ready = 0;
        rst = 1;
        tick();
        check("t6_rst_recv", outs, 0);
        rst = 0;
        tick();
        token(0, 1);
        sop(8'hC3);
        body(3, 0);
        check("t6_hs_before_rst", {hs_req, data_accept, toggle}, 3'b111);
        tick();
        rst = 1;
        tick();
        check("t6_rst_hs", outs, 0);
        rst = 0;
        tick();
        check("t6_idle_after_rst", outs, 0);
        token(0, 1);
        check("t6_restart", rx_data_on, 1);
        sop(8'hC3);
        body(2, 0);
        check("t6_restart_ack", {hs_req, hs_pid, data_accept}, {1'b1, 4'b0010, 1'b1});
        ack_hs("t6_release");

`ifdef USB_RX_STALL_EN
        ep_stall = 1;
        token(0, 1);
        sop(8'hC3);
        body(2, 0);
        check("stall_hs", {hs_req, hs_pid, data_accept, data_drop}, {1'b1, 4'b1110, 2'b00});
        ack_hs("stall_release");
        token(0, 1);
        sop(8'hC3);
        body(2, 1);
        check("stall_crc_err", {err_pulse, hs_req}, 2'b10);
        token(1, 1);
        sop(8'hC3);
        body(2, 0);
        check("stall_setup_ack", {hs_req, hs_pid, data_accept}, {1'b1, 4'b0010, 1'b1});
        ack_hs("stall_setup_release");
        ep_stall = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
